// File: rtl/cache_line_mem_responder.sv
// Memory-side responder: expands one cache-line request into LINE_WORDS
// single-word en/ack transactions. Optional watchdog: CACHE_MEM_TIMEOUT_EN.
module cache_line_mem_responder #(
    parameter int LINE_WORDS     = 8,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_en_in,
    input  logic                          req_write_in,
    input  logic [ADDR_W-1:0]             req_addr_in,
    input  logic [31:0]                   wdata_in,
    output logic [31:0]                   rdata_out,
    output logic                          beat_valid_out,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx_out,
    output logic                          done_out,
    output logic                          busy_out,
    output logic                          err_out,
    output logic                          mem_en_out,
    output logic                          mem_we_out,
    output logic [ADDR_W-1:0]             mem_addr_out,
    output logic [31:0]                   mem_wdata_out,
    input  logic [31:0]                   mem_rdata_in,
    input  logic                          mem_ack_in
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    // GAP is the cycle between beats: en is low, the beat pulse is shown
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              en_q, en_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              timeout;

`ifdef CACHE_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign timeout = (state_q == ST_XFER) && !mem_ack_in &&
                     (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // count XFER cycles without ack; restart per beat and per request
    always_comb begin
        wait_d = wait_q;
        if (state_q != ST_XFER || mem_ack_in || timeout) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    // watchdog compiled out; a beat waits for its ack forever
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        en_d    = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req_en_in) begin
                    addr_d  = req_addr_in & LINE_MASK;
                    we_d    = req_write_in;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                en_d = 1'b1;
                if (mem_ack_in) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_in;
                    end
                    en_d    = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_GAP;
                end else if (timeout) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    en_d    = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign rdata_out      = rdata_q;
    assign beat_valid_out = valid_q;
    assign beat_idx_out   = cnt_q;
    assign done_out       = done_q;
    assign busy_out       = busy_q;
    assign err_out        = err_q;
    assign mem_en_out     = en_q;
    assign mem_we_out     = en_q & we_q;
    assign mem_addr_out   = en_q ?
        (addr_q | ADDR_W'({cnt_q, 2'b00})) : '0;
    assign mem_wdata_out  = (en_q && we_q) ? wdata_in : '0;

    // a completion strobe between beats means the memory broke the handshake
    assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_ack_in && state_q == ST_GAP));

endmodule
